// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Purpose  : Shared CSR types, UART receiver CSR addresses, status bit
//            positions and receiver state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    typedef logic [31:0] word_t;
    typedef logic [11:0] csr_addr_t;
    typedef logic [4:0]  reg_idx_t;
    typedef logic [2:0]  csr_op_t;

    // CSR operations use the funct3 encoding; bit 2 marks the immediate forms
    localparam csr_op_t c_csr_rw  = 3'b001;
    localparam csr_op_t c_csr_rs  = 3'b010;
    localparam csr_op_t c_csr_rc  = 3'b011;
    localparam csr_op_t c_csr_rwi = 3'b101;
    localparam csr_op_t c_csr_rsi = 3'b110;
    localparam csr_op_t c_csr_rci = 3'b111;

    localparam csr_addr_t c_uart_rx_data_addr   = 12'hBC0;
    localparam csr_addr_t c_uart_rx_status_addr = 12'hBC1;
    localparam int        c_uart_rx_depth       = 8;

    localparam int c_uart_rx_not_empty_bit = 0;
    localparam int c_uart_rx_full_bit      = 1;
    localparam int c_uart_rx_ovr_bit       = 2;
    localparam int c_uart_rx_ferr_bit      = 3;
    localparam int c_uart_rx_count_lsb     = 4;
    localparam int c_uart_rx_irq_mask_bit  = 8;

    typedef logic [1:0] uart_rx_state_t;
    localparam uart_rx_state_t c_idle  = 2'd0;
    localparam uart_rx_state_t c_start = 2'd1;
    localparam uart_rx_state_t c_data  = 2'd2;
    localparam uart_rx_state_t c_stop  = 2'd3;

    function automatic word_t csr_operand(input csr_op_t op, input reg_idx_t zimm,
                                          input word_t data);
        return op[2] ? {27'b0, zimm} : data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Synchronous FIFO for received bytes; a push into a full FIFO is
//            accepted only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (c_aw + 1)'(DEPTH));
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 serial receiver with receive FIFO behind a data CSR (read to
//            pop) and a status CSR (FIFO state, sticky W1C errors).
//            Define UART_RX_IRQ_EN to add the masked irq output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int        CLK_DIVISOR = 174,
    parameter int        DEPTH       = c_uart_rx_depth,
    parameter csr_addr_t DATA_ADDR   = c_uart_rx_data_addr,
    parameter csr_addr_t STATUS_ADDR = c_uart_rx_status_addr
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        csr_enable,
    input  logic [11:0] csr_addr,
    input  logic [4:0]  rs1_zimm,
    input  logic [31:0] rs1_data,
    input  logic [2:0]  csr_op,
    output logic [31:0] csr_out
`ifdef UART_RX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int c_cw = $clog2(CLK_DIVISOR);
    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_cw-1:0] c_half = c_cw'(CLK_DIVISOR / 2 - 1);
    localparam logic [c_cw-1:0] c_full = c_cw'(CLK_DIVISOR - 1);

    logic [1:0]     r_sync;
    logic           r_rxs_prev;
    logic           w_rxs;
    logic           w_fall;

    uart_rx_state_t r_state;
    uart_rx_state_t w_state_next;
    logic [c_cw-1:0] r_cnt;
    logic           w_cnt_zero;
    logic [2:0]     r_bit_idx;
    logic [7:0]     r_shift;

    logic           w_load_half;
    logic           w_load_full;
    logic           w_shift;
    logic           w_clr_idx;
    logic           w_push_req;
    logic           w_set_ferr;

    logic [7:0]     w_head;
    logic           w_empty;
    logic           w_full;
    logic [c_aw:0]  w_count;
    logic [31:0]    w_count_wide;
    logic [3:0]     w_count_disp;

    logic           w_data_sel;
    logic           w_status_sel;
    logic           w_pop;
    logic           w_status_wr;
    word_t          w_operand;
    logic           w_set_ovr;
    logic           r_ovr;
    logic           r_ferr;
    word_t          w_status;
    logic           w_unused;

    // ------------------------------------------------------------------
    // Input synchronizer; flops reset to the idle line level
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync     <= 2'b11;
            r_rxs_prev <= 1'b1;
        end else begin
            r_sync     <= {r_sync[0], rx};
            r_rxs_prev <= r_sync[1];
        end
    end

    assign w_rxs      = r_sync[1];
    assign w_fall     = r_rxs_prev && !w_rxs;
    assign w_cnt_zero = (r_cnt == '0);

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:  if (w_fall) w_state_next = c_start;
            c_start: if (w_cnt_zero) w_state_next = w_rxs ? c_idle : c_data;
            c_data:  if (w_cnt_zero && (r_bit_idx == 3'd7)) w_state_next = c_stop;
            c_stop:  if (w_cnt_zero) w_state_next = c_idle;
            default: w_state_next = c_idle;
        endcase
    end

    always_comb begin
        w_load_half = 1'b0;
        w_load_full = 1'b0;
        w_shift     = 1'b0;
        w_clr_idx   = 1'b0;
        w_push_req  = 1'b0;
        w_set_ferr  = 1'b0;
        case (r_state)
            c_idle: begin
                w_load_half = w_fall;
            end
            c_start: begin
                if (w_cnt_zero && !w_rxs) begin
                    w_load_full = 1'b1;
                    w_clr_idx   = 1'b1;
                end
            end
            c_data: begin
                if (w_cnt_zero) begin
                    w_shift     = 1'b1;
                    w_load_full = 1'b1;
                end
            end
            c_stop: begin
                if (w_cnt_zero) begin
                    w_push_req = w_rxs;
                    w_set_ferr = !w_rxs;
                end
            end
            default: begin
                w_load_half = 1'b0;
            end
        endcase
    end

    // Counter free-runs (wrapping) outside of loads; only its zero matters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (w_load_half) begin
                r_cnt <= c_half;
            end else if (w_load_full) begin
                r_cnt <= c_full;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_clr_idx) begin
                r_bit_idx <= '0;
            end else if (w_shift) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            if (w_shift) begin
                r_shift <= {w_rxs, r_shift[7:1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0] w_fifo_dout;

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push_req),
        .pop   (w_pop),
        .din   (r_shift),
        .dout  (w_fifo_dout),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count)
    );

    // Storage is not reset, so hide stale contents while empty
    assign w_head       = w_empty ? 8'h00 : w_fifo_dout;
    assign w_count_wide = 32'(w_count);
    assign w_count_disp = (w_count_wide > 32'd15) ? 4'hF : w_count_wide[3:0];

    // ------------------------------------------------------------------
    // CSR access and sticky errors
    // ------------------------------------------------------------------
    assign w_data_sel   = (csr_addr == DATA_ADDR);
    assign w_status_sel = (csr_addr == STATUS_ADDR);
    assign w_pop        = csr_enable && w_data_sel && !w_empty;
    assign w_status_wr  = csr_enable && w_status_sel;
    assign w_operand    = csr_operand(csr_op, rs1_zimm, rs1_data);
    assign w_set_ovr    = w_push_req && w_full && !w_pop;

    // Setting an error takes priority over a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (w_set_ovr) begin
                r_ovr <= 1'b1;
            end else if (w_status_wr && w_operand[c_uart_rx_ovr_bit]) begin
                r_ovr <= 1'b0;
            end
            if (w_set_ferr) begin
                r_ferr <= 1'b1;
            end else if (w_status_wr && w_operand[c_uart_rx_ferr_bit]) begin
                r_ferr <= 1'b0;
            end
        end
    end

`ifdef UART_RX_IRQ_EN
    logic r_irq_mask;
    logic r_irq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_mask <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_status_wr) begin
                case (csr_op[1:0])
                    2'b01:   r_irq_mask <= w_operand[c_uart_rx_irq_mask_bit];
                    2'b10:   r_irq_mask <= r_irq_mask | w_operand[c_uart_rx_irq_mask_bit];
                    2'b11:   r_irq_mask <= r_irq_mask & ~w_operand[c_uart_rx_irq_mask_bit];
                    default: r_irq_mask <= r_irq_mask;
                endcase
            end
            r_irq <= !w_empty && r_irq_mask;
        end
    end

    assign irq = r_irq;
`endif

    always_comb begin
        w_status                                  = '0;
        w_status[c_uart_rx_not_empty_bit]         = !w_empty;
        w_status[c_uart_rx_full_bit]              = w_full;
        w_status[c_uart_rx_ovr_bit]               = r_ovr;
        w_status[c_uart_rx_ferr_bit]              = r_ferr;
        w_status[c_uart_rx_count_lsb +: 4]        = w_count_disp;
`ifdef UART_RX_IRQ_EN
        w_status[c_uart_rx_irq_mask_bit]          = r_irq_mask;
`endif
    end

    always_comb begin
        csr_out = '0;
        if (w_data_sel) begin
            csr_out = {w_empty, 23'b0, w_head};
        end else if (w_status_sel) begin
            csr_out = w_status;
        end
    end

    // Operand bits beyond the W1C/mask fields carry no meaning here
    assign w_unused = ^{w_operand, csr_op};

endmodule
`default_nettype wire
